label_packer: RTL and testbench
===============================

# label_packer

Output-side companion to the point-labelling pipeline: receives the unthrottled 8-bit label stream (`tdata`/`tvalid`/`tlast`, no ready) produced by the labelling block and packs it into 64-bit AXI4-Stream beats for the DMA S2MM channel. Bytes are packed little-endian and buffered in a FIFO so the DMA can apply backpressure without stalling the labeller. A frame's last label closes the current word, zero-pads it and marks it with `m_tlast`.

## Interface
- `IN_WIDTH`, 8, label width in bits; fixed at 8.
- `OUT_WIDTH`, 64, output beat width; `OUT_WIDTH/IN_WIDTH` = 8 bytes per beat.
- `FIFO_DEPTH`, 16, output FIFO depth in beats; power of two, ≥ 2.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_tdata`  in  IN_WIDTH  label byte.
- `s_tvalid`  in  1  byte valid; the source cannot be stalled.
- `s_tlast`  in  1  last byte of frame; qualified by `s_tvalid`.
- `m_tdata`  out  OUT_WIDTH  packed beat; byte k in bits [8k+7:8k].
- `m_tkeep`  out  OUT_WIDTH/8  byte enables.
- `m_tvalid`  out  1  beat valid.
- `m_tready`  in  1  DMA ready.
- `m_tlast`  out  1  last beat of frame.
- `overflow`  out  1  sticky; set when a completed beat is dropped because the FIFO is full.
- `frames_done`  out  16  count of beats accepted with `m_tlast`; wraps at 2^16.

## Operation
- Accumulator: 64-bit `acc`, 8-bit `keep_acc`, 3-bit `byte_idx`.
- On `s_tvalid`, write `s_tdata` into `acc[8*byte_idx +: 8]`, set `keep_acc[byte_idx]`, then increment `byte_idx`.
- A beat completes when `byte_idx == 7` or `s_tlast` is high. The completed beat is {acc with current byte merged, keep, last = `s_tlast`}.
  - Bytes above the last written byte are 0x00, and their keep bits are 0.
  - `acc`, `keep_acc` and `byte_idx` clear to 0 in the same cycle.
- `s_tlast` with `byte_idx == 7`: one beat, keep 0xFF, last = 1.
- Bytes are never merged across frames.
- Packer states (derived from `byte_idx`/`keep_acc`):
  - EMPTY: no bytes held. Any valid byte moves to FILL, or pushes and stays EMPTY if `s_tlast` is set.
  - FILL: 1–7 bytes held. Completion pushes and returns to EMPTY.
- FIFO is first-word-fall-through, storing {data, keep, last}.
  - Push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the beat is discarded and `overflow` is set. The accumulator still clears, and later bytes pack normally.
- Output: `m_tvalid` = FIFO not empty. Pop on `m_tvalid && m_tready`.
  - `m_tdata`/`m_tkeep`/`m_tlast` hold stable while `m_tvalid && !m_tready`.
  - `m_tvalid` never depends on `m_tready`.
- `frames_done` increments on every handshake with `m_tlast` = 1.
- `s_tvalid` low: nothing changes in the accumulator, whatever the value of `s_tdata`/`s_tlast`.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `m_tkeep`=0, `overflow`=0, `frames_done`=0. FIFO empty, accumulator cleared.
  - Reset mid-frame discards held bytes and buffered beats. The first byte after release starts at byte 0.
- Latency: the byte completing a beat is sampled at edge N; `m_tvalid` is high after edge N, i.e. in cycle N+1, if the FIFO was empty.
- Throughput:
  - Input: one byte per cycle, sustained, no bubbles required.
  - Output: one beat per cycle while `m_tready` is high.
- Full FIFO plus simultaneous push and pop: both take effect, occupancy is unchanged, no overflow.
- `overflow` stays set until `areset`.
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally. Full = MSBs differ and the rest are equal.

## Test plan
- Bytes 0x01..0x08 on consecutive cycles, `s_tlast` on 0x08, `m_tready`=1 → one beat 0x0807060504030201, keep 0xFF, last 1, one cycle after the 8th byte; `frames_done`=1.
- 11 bytes 0x10..0x1A, last on 0x1A → beat 1: 0x1716151413121110, keep 0xFF, last 0; beat 2: 0x00000000001A1918, keep 0x07, last 1.
- Single byte 0xAB with `s_tlast` → 0x00000000000000AB, keep 0x01, last 1. Gaps of `s_tvalid`=0 inside a frame leave packing unaffected.
- `m_tready`=0, 128 bytes streamed (FIFO_DEPTH 16) → 16 beats held, `overflow`=0, `m_tdata` stable. A further 8 bytes → `overflow`=1, that beat lost. Releasing ready drains exactly 16 beats in order.
- FIFO full, `m_tready`=1 in the same cycle a 17th beat completes → no overflow; 17 beats delivered.
- `areset` pulsed after 5 bytes of a frame and with 3 beats buffered → outputs return to reset values. A following 8-byte frame 0xF0..0xF7 yields 0xF7F6F5F4F3F2F1F0 with no residue.

Source files
------------

// File: rtl/label_packer.sv
// rtl/label_packer.sv - packs an unthrottled 8-bit label stream into 64-bit AXI4-Stream beats
// Little-endian byte packing into an accumulator, buffered by a first-word-fall-through FIFO.
module label_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [IN_WIDTH-1:0]    s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic [OUT_WIDTH-1:0]   m_tdata,
  output logic [OUT_WIDTH/8-1:0] m_tkeep,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   overflow,
  output logic [15:0]            frames_done
);

  localparam int BYTES   = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W   = $clog2(BYTES);
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = OUT_WIDTH + BYTES + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [BYTES-1:0]     keep_acc;
  logic [IDX_W-1:0]     byte_idx;

  logic [OUT_WIDTH-1:0] beat_data;
  logic [BYTES-1:0]     beat_keep;
  logic                 complete;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [ENTRY_W-1:0]   rd_entry;

  // Merge the incoming byte into the held bytes; untouched lanes stay zero because
  // the accumulator is cleared whenever a beat completes.
  always_comb begin
    beat_data = acc;
    beat_keep = keep_acc;
    for (int k = 0; k < BYTES; k++) begin
      if (byte_idx == IDX_W'(k)) begin
        beat_data[k*IN_WIDTH +: IN_WIDTH] = s_tdata;
        beat_keep[k] = 1'b1;
      end
    end
  end

  assign complete = s_tvalid && (s_tlast || (byte_idx == LAST_IDX));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc      <= '0;
      keep_acc <= '0;
      byte_idx <= '0;
    end else if (s_tvalid) begin
      if (complete) begin
        acc      <= '0;
        keep_acc <= '0;
        byte_idx <= '0;
      end else begin
        acc      <= beat_data;
        keep_acc <= beat_keep;
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop   = !empty && m_tready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push  = complete && (!full || pop);

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {beat_data, beat_keep, s_tlast};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      frames_done <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (complete && !push) begin
        overflow <= 1'b1;
      end
      if (pop && m_tlast) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  // Head entry is masked while empty so outputs read as zero out of reset.
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : rd_entry[ENTRY_W-1 -: OUT_WIDTH];
  assign m_tkeep  = empty ? '0 : rd_entry[BYTES:1];
  assign m_tlast  = empty ? 1'b0 : rd_entry[0];

endmodule

// File: tb/tb_label_packer.sv
// tb/tb_label_packer.sv - scoreboard bench for label_packer
// Expected beats are queued as stimulus is driven; observed handshakes are compared in each task.
module tb_label_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        overflow;
  logic [15:0] frames_done;

  int checks = 0;
  int fails  = 0;

  logic [72:0] exp_q[$];
  logic [72:0] obs_q[$];

  label_packer #(.IN_WIDTH(8), .OUT_WIDTH(64), .FIFO_DEPTH(16)) dut (
    .aclk(aclk), .areset(areset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast),
    .overflow(overflow), .frames_done(frames_done)
  );

  always #5 aclk = ~aclk;

  // One clock cycle of stimulus; records any output handshake taken at the coming edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge aclk);
    if (m_tvalid && m_tready) obs_q.push_back({m_tdata, m_tkeep, m_tlast});
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic test_reset;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep, overflow, frames_done} !== 91'd0) begin
      fails++;
      $display("FAIL reset_values: got valid=%b last=%b data=%h keep=%h ovf=%b frames=%0d, want all zero",
               m_tvalid, m_tlast, m_tdata, m_tkeep, overflow, frames_done);
    end
    areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_full_beat;
    logic [72:0] e, o;
    m_tready = 1'b1;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), i == 8);
    exp_q.push_back({64'h0807060504030201, 8'hFF, 1'b1});
    checks++;
    if (m_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL full_beat_latency: m_tvalid=%b one cycle after 8th byte, want 1", m_tvalid);
    end
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL full_beat_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL full_beat_data: got %h, want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (frames_done !== 16'd1) begin
      fails++;
      $display("FAIL full_beat_frames: got %0d, want 1", frames_done);
    end
  endtask

  task automatic test_two_beats_with_gaps;
    logic [72:0] e, o;
    m_tready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, 8'(8'h10 + i), i == 10);
      if (i % 3 == 1) idle(2);
    end
    exp_q.push_back({64'h1716151413121110, 8'hFF, 1'b0});
    exp_q.push_back({64'h00000000001A1918, 8'h07, 1'b1});
    cycle(1'b1, 8'hAB, 1'b1);
    exp_q.push_back({64'h00000000000000AB, 8'h01, 1'b1});
    idle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL partial_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL partial_data: got %h, want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (frames_done !== 16'd3) begin
      fails++;
      $display("FAIL partial_frames: got %0d, want 3", frames_done);
    end
  endtask

  task automatic test_full_simultaneous;
    logic [72:0] e, o;
    logic [63:0] d;
    m_tready = 1'b0;
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8'h80 + 8*b + k);
      exp_q.push_back({d, 8'hFF, 1'b0});
    end
    for (int i = 0; i < 136; i++) begin
      if (i == 135) m_tready = 1'b1;
      cycle(1'b1, 8'(8'h80 + i), 1'b0);
    end
    idle(20);
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL simul_overflow: got %b, want 0", overflow);
    end
    checks++;
    if (obs_q.size() != 17) begin
      fails++;
      $display("FAIL simul_count: got %0d beats, want 17", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL simul_data: got %h, want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_overflow;
    logic [72:0] e, o;
    logic [63:0] d;
    m_tready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8*b + k);
      exp_q.push_back({d, 8'hFF, 1'b0});
    end
    for (int i = 0; i < 128; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 40) begin
        checks++;
        if (m_tdata !== 64'h0706050403020100) begin
          fails++;
          $display("FAIL ovf_head_early: got %h, want 0706050403020100", m_tdata);
        end
      end
    end
    checks++;
    if (overflow !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 64'h0706050403020100) begin
      fails++;
      $display("FAIL ovf_full_hold: ovf=%b valid=%b data=%h, want 0 1 0706050403020100",
               overflow, m_tvalid, m_tdata);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'hEE, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %b, want 1", overflow);
    end
    m_tready = 1'b1;
    idle(22);
    checks++;
    if (obs_q.size() != 16) begin
      fails++;
      $display("FAIL ovf_drain_count: got %0d beats, want 16", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL ovf_drain_data: got %h, want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (overflow !== 1'b1 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b valid=%b, want 1 0", overflow, m_tvalid);
    end
  endtask

  task automatic test_reset_midframe;
    logic [72:0] e, o;
    m_tready = 1'b0;
    for (int i = 0; i < 29; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    checks++;
    if (m_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre: m_tvalid=%b with beats buffered, want 1", m_tvalid);
    end
    s_tvalid = 1'b0;
    areset   = 1'b1;
    #2;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep, overflow, frames_done} !== 91'd0) begin
      fails++;
      $display("FAIL midreset_values: got valid=%b last=%b data=%h keep=%h ovf=%b frames=%0d, want all zero",
               m_tvalid, m_tlast, m_tdata, m_tkeep, overflow, frames_done);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    obs_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hF0 + i), i == 7);
    exp_q.push_back({64'hF7F6F5F4F3F2F1F0, 8'hFF, 1'b1});
    idle(3);
    checks++;
    if (obs_q.size() != 1) begin
      fails++;
      $display("FAIL midreset_count: got %0d beats, want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midreset_data: got %h, want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (frames_done !== 16'd1) begin
      fails++;
      $display("FAIL midreset_frames: got %0d, want 1", frames_done);
    end
  endtask

  initial begin
    test_reset;
    test_full_beat;
    test_two_beats_with_gaps;
    test_full_simultaneous;
    test_overflow;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
